// File: rtl/ntt_arith_pkg.sv
// ----------------------------------------------------------------------------
// ntt_arith_pkg
// Shared arithmetic constants and types for the NTT/FFT butterfly datapath.
//   DATA_WIDTH : operand/result width
//   MODULUS    : prime modulus p = 2^64 - 2^32 + 1
//   ext_word_t : DATA_WIDTH+1 bit word (value plus carry/borrow bit)
//   stage_t    : stage-1 payload {diff, borrow, op_add}
// ----------------------------------------------------------------------------
package ntt_arith_pkg;

    localparam int DATA_WIDTH = 64;
    localparam logic [DATA_WIDTH-1:0] MODULUS = 64'hFFFF_FFFF_0000_0001;

    typedef logic [DATA_WIDTH:0] ext_word_t;

    // borrow holds the borrow of a - b for subtracts and the carry-out of
    // a + b for adds, so {borrow, diff} is always the full-width S1 result.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] diff;
        logic                  borrow;
        logic                  op_add;
    } stage_t;

endpackage

// File: rtl/cla64_sub_core.sv
// ----------------------------------------------------------------------------
// cla64_sub_core
// Combinational carry-lookahead add/subtract core. With i_sub = 1 it computes
// a + ~b + 1 and reports the borrow as the inverted carry-out; with i_sub = 0
// it computes a + b and o_borrow is the inverted carry-out.
// Structure: 4-bit lookahead groups, group generate/propagate chained across
// groups, bit carries re-expanded inside each group.
// Ports:
//   i_a, i_b  : operands (DATA_WIDTH)
//   i_sub     : 1 = subtract, 0 = add
//   o_diff    : low DATA_WIDTH bits of the sum
//   o_borrow  : ~carry_out
// ----------------------------------------------------------------------------
module cla64_sub_core
    import ntt_arith_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_sub,
    output logic [DATA_WIDTH-1:0] o_diff,
    output logic                  o_borrow
);

    localparam int NG = DATA_WIDTH / 4;

    logic [DATA_WIDTH-1:0] w_b_eff;
    logic [DATA_WIDTH-1:0] w_g;
    logic [DATA_WIDTH-1:0] w_p;

    assign w_b_eff = i_sub ? ~i_b : i_b;
    assign w_g     = i_a & w_b_eff;
    assign w_p     = i_a ^ w_b_eff;

    always_comb begin
        logic [NG:0]           gc;
        logic [NG-1:0]         gg;
        logic [NG-1:0]         gp;
        logic [DATA_WIDTH-1:0] c;
        gc = '0;
        gg = '0;
        gp = '0;
        c  = '0;
        gc[0] = i_sub;
        for (int k = 0; k < NG; k++) begin
            gp[k] = &w_p[4*k +: 4];
            gg[k] = w_g[4*k+3]
                  | (w_p[4*k+3] & w_g[4*k+2])
                  | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                  | ((&w_p[4*k+1 +: 3]) & w_g[4*k]);
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        for (int k = 0; k < NG; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = w_g[4*k] | (w_p[4*k] & gc[k]);
            c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                     | (w_p[4*k+1] & w_p[4*k] & gc[k]);
            c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                     | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                     | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & gc[k]);
        end
        o_diff   = w_p ^ c;
        o_borrow = ~gc[NG];
    end

endmodule

// File: rtl/cla64_modsub_pipe.sv
// ----------------------------------------------------------------------------
// cla64_modsub_pipe
// Two-stage pipelined modular subtractor: result = (a - b) mod MODULUS.
//   S1: CLA a + ~b + 1, registers {diff, borrow}.
//   S2: adds MODULUS back when a borrow occurred, registers result and wrap.
// Valid/ready on both sides; in_ready is combinational from out_ready (no
// skid buffer). Synchronous active-high reset discards in-flight items.
// Optional build macro MODSUB_ADD_MODE_EN adds op_add: when set, the block
// computes (a + b) mod MODULUS and wrap flags that the reduction fired.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake
//   a_in, b_in            : minuend / subtrahend
//   op_add                : (MODSUB_ADD_MODE_EN only) 1 = add mode
//   out_valid / out_ready : result handshake
//   result, wrap          : modular result, modulus correction applied
// ----------------------------------------------------------------------------
module cla64_modsub_pipe
    import ntt_arith_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
`ifdef MODSUB_ADD_MODE_EN
    input  logic                  op_add,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  wrap
);

    stage_t                r_s1;
    logic                  r_s1_valid;
    logic                  r_s2_valid;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_wrap;

    logic                  w_s2_adv;
    logic                  w_accept;
    logic                  w_core_sub;
    logic [DATA_WIDTH-1:0] w_core_diff;
    logic                  w_core_borrow;
    stage_t                w_s1_next;
    logic [DATA_WIDTH-1:0] w_sub_fix;
    logic [DATA_WIDTH-1:0] w_s2_result;
    logic                  w_s2_wrap;

    assign w_s2_adv = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready = !r_s1_valid || w_s2_adv;
    assign w_accept = in_valid && in_ready;

`ifdef MODSUB_ADD_MODE_EN
    assign w_core_sub = ~op_add;
`else
    assign w_core_sub = 1'b1;
`endif

    cla64_sub_core u_core (
        .i_a      (a_in),
        .i_b      (b_in),
        .i_sub    (w_core_sub),
        .o_diff   (w_core_diff),
        .o_borrow (w_core_borrow)
    );

    always_comb begin
        w_s1_next.diff   = w_core_diff;
`ifdef MODSUB_ADD_MODE_EN
        // in add mode keep the true carry so {borrow, diff} is a + b
        w_s1_next.borrow = op_add ? ~w_core_borrow : w_core_borrow;
        w_s1_next.op_add = op_add;
`else
        w_s1_next.borrow = w_core_borrow;
        w_s1_next.op_add = 1'b0;
`endif
    end

    assign w_sub_fix = r_s1.diff + MODULUS;

`ifdef MODSUB_ADD_MODE_EN
    ext_word_t w_red;
    logic      w_red_fire;

    // s - p is non-negative exactly when the top bit of the 65-bit result is 0
    assign w_red      = {r_s1.borrow, r_s1.diff} - {1'b0, MODULUS};
    assign w_red_fire = ~w_red[DATA_WIDTH];
`else
    logic w_unused_op_add;
    assign w_unused_op_add = r_s1.op_add;
`endif

    always_comb begin
        w_s2_result = r_s1.borrow ? w_sub_fix : r_s1.diff;
        w_s2_wrap   = r_s1.borrow;
`ifdef MODSUB_ADD_MODE_EN
        if (r_s1.op_add) begin
            w_s2_result = w_red_fire ? w_red[DATA_WIDTH-1:0] : r_s1.diff;
            w_s2_wrap   = w_red_fire;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1       <= '0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_wrap     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1 <= w_s1_next;
            end
            if (w_accept) begin
                r_s1_valid <= 1'b1;
            end else if (w_s2_adv) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s2_adv) begin
                r_s2_valid <= 1'b1;
                r_result   <= w_s2_result;
                r_wrap     <= w_s2_wrap;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_cla64_modsub_pipe.sv
module tb_cla64_modsub_pipe;

    localparam logic [63:0] P = 64'hFFFF_FFFF_0000_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic        cur_op;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        wrap;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    bit last_fire_in;
    bit last_pop;
    logic [64:0] sb[$];

    always #5 clk = ~clk;

    cla64_modsub_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
`ifdef MODSUB_ADD_MODE_EN
        .op_add    (cur_op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .wrap      (wrap)
    );

    // reference: {wrap, result}
    function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic op);
        logic [64:0] s;
        logic        w;
        logic [63:0] r;
        if (op) begin
            s = {1'b0, a} + {1'b0, b};
            w = (s >= {1'b0, P});
            r = w ? 64'(s - {1'b0, P}) : s[63:0];
        end else begin
            w = (a < b);
            r = w ? (a - b + P) : (a - b);
        end
        return {w, r};
    endfunction

    // one clock: sample handshakes mid-cycle, score outputs, log accepts
    task automatic tick();
        logic [64:0] e;
        @(negedge clk);
        last_fire_in = 1'b0;
        last_pop     = 1'b0;
        if (!rst) begin
            if (out_valid && out_ready) begin
                checks++;
                last_pop = 1'b1;
                n_out++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got result=%h wrap=%b, required no output", result, wrap);
                end else begin
                    e = sb.pop_front();
                    if ({wrap, result} !== e) begin
                        errors++;
                        $display("FAIL sb_data: got wrap=%b result=%h, required wrap=%b result=%h",
                                 wrap, result, e[64], e[63:0]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(a_in, b_in, cur_op));
                last_fire_in = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [63:0] a, input logic [63:0] b, input logic op);
        int lat;
        a_in = a; b_in = b; cur_op = op; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (!last_fire_in) begin
            errors++;
            $display("FAIL accept: in_ready=%b, required accept of a=%h b=%h", in_ready, a, b);
        end
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!last_pop && lat < 10);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL latency: got %0d cycles, required 2 (a=%h b=%h)", lat, a, b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0; cur_op = 1'b0;
        tick();
        tick();
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
        if (result !== 64'd0)   begin errors++; $display("FAIL rst_result: got %h, required 0", result); end
        if (wrap !== 1'b0)      begin errors++; $display("FAIL rst_wrap: got %b, required 0", wrap); end
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        send_one(64'd5, 64'd3, 1'b0);
        send_one(64'd3, 64'd5, 1'b0);
        send_one(64'h1234, 64'h1234, 1'b0);
        send_one(64'd0, P - 64'd1, 1'b0);
        send_one(P - 64'd1, P - 64'd1, 1'b0);
        send_one(64'd0, 64'd1, 1'b0);
    endtask

`ifdef MODSUB_ADD_MODE_EN
    task automatic test_add_mode();
        send_one(P - 64'd1, 64'd2, 1'b1);
        send_one(64'd1, 64'd2, 1'b1);
        send_one(P - 64'd1, P - 64'd1, 1'b1);
        send_one(64'd9, 64'd4, 1'b0);
    endtask
`endif

    task automatic test_back_to_back();
        logic [63:0] va[8];
        logic [63:0] vb[8];
        logic [63:0] held;
        int sent;
        int start;
        for (int i = 0; i < 8; i++) begin
            va[i] = {$urandom, $urandom} % P;
            vb[i] = {$urandom, $urandom} % P;
        end
        va[1] = 64'd10; vb[1] = 64'd20;
        sent  = 0;
        start = n_out;
        held  = '0;
        cur_op = 1'b0;
        for (int cyc = 0; cyc < 60 && (n_out - start) < 8; cyc++) begin
            in_valid  = (sent < 8);
            if (sent < 8) begin
                a_in = va[sent];
                b_in = vb[sent];
            end
            out_ready = !(cyc >= 3 && cyc <= 5);
            #1;
            if (cyc >= 3 && cyc <= 5) begin
                checks += 2;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready: cycle %0d got %b, required 0", cyc, in_ready);
                end
                if (cyc == 3) begin
                    held = result;
                    if (out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_out_valid: got %b, required 1", out_valid);
                    end
                end else if (result !== held) begin
                    errors++;
                    $display("FAIL stall_hold: cycle %0d got %h, required %h", cyc, result, held);
                end
            end
            tick();
            if (last_fire_in) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks += 2;
        if ((n_out - start) != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, required 8", n_out - start);
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_leftover: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        cur_op = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        a_in = 64'd11; b_in = 64'd4;
        tick();
        a_in = 64'd20; b_in = 64'd30;
        tick();
        in_valid = 1'b0;
        #1;
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL full_out_valid: got %b, required 1", out_valid); end
        if (in_ready !== 1'b0)  begin errors++; $display("FAIL full_in_ready: got %b, required 0", in_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b, required 0", out_valid); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL flush_in_ready: got %b, required 1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        send_one(64'd7, 64'd2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_vectors();
`ifdef MODSUB_ADD_MODE_EN
        test_add_mode();
`endif
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_sb: got %0d pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
